// File: rtl/u409_cycle_router.sv
// U409 bus cycle router: decodes CPU transfer starts into one local target select,
// waits for that target's ack and issues a single TA (ack) or TEA (timeout) termination.
module u409_cycle_router #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [7:0]  AC_PAGE     = 8'hE8
) (
    input  logic        CLK40,
    input  logic        RESET,
    input  logic        TSn,
    input  logic        RnW,
    input  logic [15:0] A,
    input  logic        CONFIGURED,
    input  logic        LIDE_EN,
    input  logic        BRIDGE_EN,
    input  logic        PRO_EN,
    input  logic [7:0]  BRIDGE_BASE,
    input  logic [6:0]  LIDE_BASE,
    input  logic [3:0]  PRO_BASE,
    input  logic        AC_TACK,
    input  logic        LIDE_ACK,
    input  logic        BRIDGE_ACK,
    output logic        AUTOCONFIG_SPACE,
    output logic        LIDE_SEL,
    output logic        BRIDGE_SEL,
    output logic        PRO_SEL,
    output logic        CYC_RnW,
    output logic        TA,
    output logic        TEA,
    output logic        BUSY
);

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StWait, StTerm} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  sel_q, sel_d;  // {ac, lide, bridge, pro}
    logic        rnw_q, rnw_d;
    logic        ta_q, ta_d;
    logic        tea_q, tea_d;
    logic        busy_q, busy_d;
    logic [3:0]  hit;
    logic        hi_zero;
    logic        ack;

    // A holds A[31:16]: A[15:8] is A[31:24], A[7:0] is A[23:16].
    assign hi_zero = (A[15:8] == 8'h00);

    always_comb begin
        hit = 4'b0000;
        if (!CONFIGURED && hi_zero && A[7:0] == AC_PAGE) begin
            hit = 4'b1000;
        end else if (LIDE_EN && hi_zero && A[7:1] == LIDE_BASE) begin
            hit = 4'b0100;
        end else if (BRIDGE_EN && hi_zero && A[7:0] == BRIDGE_BASE) begin
            hit = 4'b0010;
        end else if (PRO_EN && A[15:12] == PRO_BASE && A[15:12] != 4'h0) begin
            hit = 4'b0001;
        end
    end

    // Only the selected target's ack terminates; bridge ack serves both bridge windows.
    assign ack = (sel_q[3] & AC_TACK) | (sel_q[2] & LIDE_ACK) |
                 ((sel_q[1] | sel_q[0]) & BRIDGE_ACK);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        rnw_d   = rnw_q;
        busy_d  = busy_q;
        ta_d    = 1'b0;
        tea_d   = 1'b0;
        case (state_q)
            StIdle, StTerm: begin
                if (!TSn && hit != 4'b0000) begin
                    sel_d   = hit;
                    rnw_d   = RnW;
                    busy_d  = 1'b1;
                    cnt_d   = 8'h00;
                    state_d = StWait;
                end else begin
                    sel_d   = 4'b0000;
                    rnw_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (ack) begin
                    ta_d    = 1'b1;
                    sel_d   = 4'b0000;
                    rnw_d   = 1'b0;
                    state_d = StTerm;
                end else if (cnt_q == TimeoutLast) begin
                    tea_d   = 1'b1;
                    sel_d   = 4'b0000;
                    rnw_d   = 1'b0;
                    state_d = StTerm;
                end else begin
                    cnt_d = cnt_q + 8'h01;
                end
            end
            default: begin
                sel_d   = 4'b0000;
                rnw_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK40) begin
        if (RESET) begin
            state_q <= StIdle;
            cnt_q   <= 8'h00;
            sel_q   <= 4'b0000;
            rnw_q   <= 1'b0;
            ta_q    <= 1'b0;
            tea_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            rnw_q   <= rnw_d;
            ta_q    <= ta_d;
            tea_q   <= tea_d;
            busy_q  <= busy_d;
        end
    end

    assign AUTOCONFIG_SPACE = sel_q[3];
    assign LIDE_SEL         = sel_q[2];
    assign BRIDGE_SEL       = sel_q[1];
    assign PRO_SEL          = sel_q[0];
    assign CYC_RnW          = rnw_q;
    assign TA               = ta_q;
    assign TEA              = tea_q;
    assign BUSY             = busy_q;

endmodule

// File: tb/tb_u409_cycle_router.sv
// Bench for u409_cycle_router: directed cycles push expected select/termination events,
// a negedge monitor pops and compares them as the router presents them.
module tb_u409_cycle_router;

    logic        CLK40 = 1'b0;
    logic        RESET, TSn, RnW, CONFIGURED, LIDE_EN, BRIDGE_EN, PRO_EN;
    logic [15:0] A;
    logic [7:0]  BRIDGE_BASE;
    logic [6:0]  LIDE_BASE;
    logic [3:0]  PRO_BASE;
    logic        AC_TACK, LIDE_ACK, BRIDGE_ACK;
    logic        AUTOCONFIG_SPACE, LIDE_SEL, BRIDGE_SEL, PRO_SEL, CYC_RnW, TA, TEA, BUSY;

    u409_cycle_router dut (
        .CLK40(CLK40), .RESET(RESET), .TSn(TSn), .RnW(RnW), .A(A),
        .CONFIGURED(CONFIGURED), .LIDE_EN(LIDE_EN), .BRIDGE_EN(BRIDGE_EN), .PRO_EN(PRO_EN),
        .BRIDGE_BASE(BRIDGE_BASE), .LIDE_BASE(LIDE_BASE), .PRO_BASE(PRO_BASE),
        .AC_TACK(AC_TACK), .LIDE_ACK(LIDE_ACK), .BRIDGE_ACK(BRIDGE_ACK),
        .AUTOCONFIG_SPACE(AUTOCONFIG_SPACE), .LIDE_SEL(LIDE_SEL), .BRIDGE_SEL(BRIDGE_SEL),
        .PRO_SEL(PRO_SEL), .CYC_RnW(CYC_RnW), .TA(TA), .TEA(TEA), .BUSY(BUSY)
    );

    always #5 CLK40 = ~CLK40;

    int cyc = 0;
    always @(posedge CLK40) cyc <= cyc + 1;

    typedef struct {
        bit         term;
        logic [3:0] sel;
        logic       rnw;
        logic       ta;
        logic       tea;
        int         at;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK40);
        #1;
    endtask

    // Drive one TSn cycle; a non-zero exp_sel means a select is expected next cycle.
    task automatic start(input logic [15:0] a, input logic rnw, input logic [3:0] exp_sel);
        ev_t e;
        TSn = 1'b0;
        A   = a;
        RnW = rnw;
        if (exp_sel != 4'b0000) begin
            e = '{term: 1'b0, sel: exp_sel, rnw: rnw, ta: 1'b0, tea: 1'b0, at: cyc + 1};
            sb.push_back(e);
        end
        tick();
        TSn = 1'b1;
    endtask

    task automatic expect_term(input logic ta, input logic tea, input int at);
        ev_t e;
        e = '{term: 1'b1, sel: 4'b0000, rnw: 1'b0, ta: ta, tea: tea, at: at};
        sb.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever a select rises or a termination pulses.
    initial begin
        logic [3:0] sel;
        logic [3:0] prev_sel;
        ev_t        e;
        prev_sel = 4'b0000;
        forever begin
            @(negedge CLK40);
            sel = {AUTOCONFIG_SPACE, LIDE_SEL, BRIDGE_SEL, PRO_SEL};
            chk("ta_tea_exclusive", {31'd0, TA & TEA}, 32'd0);
            chk("sel_onehot0", {31'd0, $onehot0(sel)}, 32'd1);
            if (sel != 4'b0000 && prev_sel == 4'b0000) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_select: got sel %0h expected none (cycle %0d)",
                             sel, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("start_kind", {31'd0, e.term}, 32'd0);
                    chk("start_sel", {28'd0, sel}, {28'd0, e.sel});
                    chk("start_rnw", {31'd0, CYC_RnW}, {31'd0, e.rnw});
                    chk("start_busy", {31'd0, BUSY}, 32'd1);
                    chk("start_cycle", cyc, e.at);
                end
            end
            if (TA || TEA) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_term: got TA %0b TEA %0b expected none (cycle %0d)",
                             TA, TEA, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("term_kind", {31'd0, e.term}, 32'd1);
                    chk("term_ta", {31'd0, TA}, {31'd0, e.ta});
                    chk("term_tea", {31'd0, TEA}, {31'd0, e.tea});
                    chk("term_sel_low", {28'd0, sel}, 32'd0);
                    chk("term_busy", {31'd0, BUSY}, 32'd1);
                    chk("term_cycle", cyc, e.at);
                end
            end
            prev_sel = sel;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int s;

    initial begin
        RESET = 1'b1; TSn = 1'b1; RnW = 1'b1; A = 16'h0000;
        CONFIGURED = 1'b0; LIDE_EN = 1'b0; BRIDGE_EN = 1'b0; PRO_EN = 1'b0;
        BRIDGE_BASE = 8'h00; LIDE_BASE = 7'h00; PRO_BASE = 4'h0;
        AC_TACK = 1'b0; LIDE_ACK = 1'b0; BRIDGE_ACK = 1'b0;
        tick(); tick();
        chk("reset_outputs", {24'd0, AUTOCONFIG_SPACE, LIDE_SEL, BRIDGE_SEL, PRO_SEL,
                              CYC_RnW, TA, TEA, BUSY}, 32'd0);
        RESET = 1'b0;
        tick();

        // Autoconfig read, ack two cycles after select.
        start(16'h00E8, 1'b1, 4'b1000);
        tick();
        AC_TACK = 1'b1;
        expect_term(1'b1, 1'b0, cyc + 1);
        tick();
        AC_TACK = 1'b0;
        tick();
        chk("ac_busy_after_term", {31'd0, BUSY}, 32'd0);
        chk("ac_ta_one_cycle", {31'd0, TA}, 32'd0);

        // LIDE write; foreign acks and a TSn during WAIT must not disturb it.
        CONFIGURED = 1'b1; LIDE_EN = 1'b1; LIDE_BASE = 7'h74;
        start(16'h00E9, 1'b0, 4'b0100);
        BRIDGE_ACK = 1'b1; AC_TACK = 1'b1;
        tick();
        BRIDGE_ACK = 1'b0; AC_TACK = 1'b0;
        TSn = 1'b0; A = 16'h00E9; RnW = 1'b1;
        tick();
        TSn = 1'b1;
        chk("lide_sel_held", {31'd0, LIDE_SEL}, 32'd1);
        chk("lide_rnw_held", {31'd0, CYC_RnW}, 32'd0);
        LIDE_ACK = 1'b1;
        expect_term(1'b1, 1'b0, cyc + 1);
        tick();
        LIDE_ACK = 1'b0;
        // Back-to-back start decoded in the TERM cycle.
        start(16'h00E8, 1'b1, 4'b0100);
        LIDE_ACK = 1'b1;
        expect_term(1'b1, 1'b0, cyc + 1);
        tick();
        LIDE_ACK = 1'b0;
        tick();
        chk("b2b_busy_after_term", {31'd0, BUSY}, 32'd0);

        // Prometheus window times out after 255 unacked WAIT cycles.
        LIDE_EN = 1'b0; PRO_EN = 1'b1; PRO_BASE = 4'h4;
        start(16'h4123, 1'b1, 4'b0001);
        expect_term(1'b0, 1'b1, cyc + 255);
        repeat (258) tick();
        chk("pro_busy_after_tea", {31'd0, BUSY}, 32'd0);

        // Misses: configured autoconfig page, and a zero Prometheus nibble.
        PRO_EN = 1'b0;
        start(16'h00E8, 1'b1, 4'b0000);
        chk("miss_busy", {31'd0, BUSY}, 32'd0);
        PRO_EN = 1'b1; PRO_BASE = 4'h0;
        start(16'h0123, 1'b1, 4'b0000);
        chk("miss_pro_zero_busy", {31'd0, BUSY}, 32'd0);
        repeat (3) tick();

        // Reset during a bridge WAIT drops the cycle; a late ack gives nothing.
        BRIDGE_EN = 1'b1; BRIDGE_BASE = 8'h12;
        start(16'h0012, 1'b0, 4'b0010);
        tick(); tick();
        RESET = 1'b1;
        tick();
        chk("midreset_outputs", {24'd0, AUTOCONFIG_SPACE, LIDE_SEL, BRIDGE_SEL, PRO_SEL,
                                 CYC_RnW, TA, TEA, BUSY}, 32'd0);
        RESET = 1'b0;
        tick();
        BRIDGE_ACK = 1'b1;
        tick();
        BRIDGE_ACK = 1'b0;
        repeat (3) tick();
        chk("midreset_busy", {31'd0, BUSY}, 32'd0);

        // LIDE beats overlapping bridge window; ack lands on the timeout edge.
        LIDE_EN = 1'b1; LIDE_BASE = 7'h74; BRIDGE_BASE = 8'hE9;
        start(16'h00E9, 1'b1, 4'b0100);
        s = cyc;
        repeat (254) tick();
        LIDE_ACK = 1'b1;
        expect_term(1'b1, 1'b0, s + 255);
        tick();
        LIDE_ACK = 1'b0;
        repeat (3) tick();

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
